ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte to the keyboard (0xED set-LEDs,
//  0xFF reset, 0xEE echo) over the open-drain clock/data pair. Its PS/2 receiver shares
//  the same lines. tx_busy tells the receiver to ignore line activity while a frame is in flight.

---
 rtl/ps2_pkg.sv | 47 ++++
 rtl/ps2_line_sync.sv | 44 ++++
 rtl/ps2_host_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 host transmitter and the PS/2 receiver
//   that shares the same clock/data pair.
//
//   Contents:
//     - frame geometry (11 bits on the wire, 10 of them shifted by the host)
//     - host command bytes understood by the keyboard
//     - transmitter state encoding (plain localparams for older tools)
//     - helpers that build the shifted part of a host frame
// -----------------------------------------------------------------------------
package ps2_pkg;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS    = 11;
  // The start bit is asserted by the request phase, so only data, parity and
  // stop are shifted out on device clock falls.
  localparam int PS2_TX_SHIFT_BITS = PS2_FRAME_BITS - 1;

  // Host-to-keyboard commands
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // Transmitter state encoding
  typedef logic [2:0] ps2_tx_state_t;

  localparam logic [2:0] TX_IDLE    = 3'd0;
  localparam logic [2:0] TX_INHIBIT = 3'd1;
  localparam logic [2:0] TX_REQ     = 3'd2;
  localparam logic [2:0] TX_SEND    = 3'd3;
  localparam logic [2:0] TX_ACK     = 3'd4;
  localparam logic [2:0] TX_DONE    = 3'd5;
  localparam logic [2:0] TX_FAIL    = 3'd6;

  // Odd parity: the parity bit makes the total count of ones (data+parity) odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Shifted frame, LSB first on the wire: data[0..7], parity, stop.
  function automatic logic [PS2_TX_SHIFT_BITS-1:0] ps2_tx_frame(input logic [7:0] data);
    return {1'b1, ps2_odd_parity(data), data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ps2_line_sync
//   Two-flop synchroniser for one raw PS/2 line plus a falling-edge detector.
//   Used once per line by the host transmitter and by the receiver.
//
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous, active-high reset
//     line_in    in   raw, asynchronous line level
//     line_sync  out  synchronised line level
//     line_fall  out  one-cycle pulse: previous sync level 1, current 0
//
//   All flops reset to 1 because an idle, released PS/2 line is pulled high;
//   this also keeps a reset from looking like a falling edge.
// -----------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= line_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign line_sync = sync_reg;
  assign line_fall = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to the keyboard
//   over the open-drain clock/data pair shared with the PS/2 receiver.
//
//   Sequence: hold clock low (inhibit) -> pull data low (start bit) ->
//   release clock -> present data, parity, stop on each device clock fall ->
//   sample the device ACK on the next fall -> wait for both lines idle.
//
//   Ports:
//     board_clk    in   system clock
//     reset        in   asynchronous, active-high
//     tx_data      in   command byte (latched when tx_valid & tx_ready)
//     tx_valid     in   send request
//     tx_ready     out  high only while idle
//     tx_busy      out  high whenever not idle; receiver ignores the lines then
//     tx_done      out  one-cycle pulse: frame acknowledged by the device
//     tx_err       out  one-cycle pulse: device NACK or timeout
//     ps2_clk_in   in   raw clock line level
//     ps2_data_in  in   raw data line level
//     ps2_clk_oe   out  1 = drive clock line low, 0 = release
//     ps2_data_oe  out  1 = drive data line low, 0 = release
//
//   Parameters:
//     INHIBIT_CYCLES  cycles the clock is held low before the start bit
//     TIMEOUT_CYCLES  cycles allowed from clock release to the ACK sample
//     CNT_W           width of the shared cycle counter (must hold both above)
//     MAX_RETRY       extra attempts after a failed frame (retry build only)
//
//   Build option:
//     PS2_TX_RETRY_EN  when defined, a failed frame is re-sent from the latched
//                      copy up to MAX_RETRY more times; tx_err pulses only
//                      after the last attempt and tx_busy stays high across
//                      the retries. When undefined, every failure reports at
//                      once and no retry counter exists.
// -----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20,
  parameter int MAX_RETRY      = 2
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  import ps2_pkg::*;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // Index of the fall that presents the stop bit; after it the frame waits for ACK.
  localparam logic [3:0]       LAST_BIT_IDX = 4'(PS2_TX_SHIFT_BITS - 1);

  // ---------------------------------------------------------------------------
  // Line synchronisers
  // ---------------------------------------------------------------------------
  logic clk_sync;
  logic clk_fall;
  logic data_sync;
  logic data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk       (board_clk),
    .rst       (reset),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk       (board_clk),
    .rst       (reset),
    .line_in   (ps2_data_in),
    .line_sync (data_sync),
    .line_fall (data_fall_unused)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ps2_tx_state_t                 state_reg;
  logic [PS2_TX_SHIFT_BITS-1:0]  frame_reg;   // copy kept for retries
  logic [PS2_TX_SHIFT_BITS-1:0]  shreg_reg;   // bits still to present
  logic [CNT_W-1:0]              cnt_reg;     // inhibit length, then timeout
  logic [3:0]                    bitcnt_reg;  // falls seen in SEND
  logic                          clk_oe_reg;
  logic                          data_oe_reg;
  logic                          retry_left;  // another attempt is allowed

  logic accept;
  assign accept = (state_reg == TX_IDLE) && tx_valid;

  // ---------------------------------------------------------------------------
  // Optional retry counter
  // ---------------------------------------------------------------------------
`ifdef PS2_TX_RETRY_EN
  localparam int                 RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0] retry_cnt_reg;

  assign retry_left = (retry_cnt_reg < RETRY_LIMIT);

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      retry_cnt_reg <= '0;
    end else if (accept) begin
      retry_cnt_reg <= '0;
    end else if ((state_reg == TX_FAIL) && retry_left) begin
      retry_cnt_reg <= retry_cnt_reg + 1'b1;
    end
  end
`else
  localparam int MAX_RETRY_UNUSED = MAX_RETRY;

  assign retry_left = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_reg   <= TX_IDLE;
      frame_reg   <= '0;
      shreg_reg   <= '0;
      cnt_reg     <= '0;
      bitcnt_reg  <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
    end else begin
      case (state_reg)
        TX_IDLE: begin
          clk_oe_reg  <= 1'b0;
          data_oe_reg <= 1'b0;
          if (accept) begin
            frame_reg  <= ps2_tx_frame(tx_data);
            cnt_reg    <= '0;
            clk_oe_reg <= 1'b1;
            state_reg  <= TX_INHIBIT;
          end
        end

        // Clock held low so the device aborts anything it was sending.
        TX_INHIBIT: begin
          clk_oe_reg <= 1'b1;
          if (cnt_reg == INHIBIT_LAST) begin
            data_oe_reg <= 1'b1;
            state_reg   <= TX_REQ;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        // One cycle with both lines low, then hand the clock to the device.
        // The start bit stays asserted on data until the first fall.
        TX_REQ: begin
          clk_oe_reg <= 1'b0;
          cnt_reg    <= '0;
          bitcnt_reg <= '0;
          shreg_reg  <= frame_reg;
          state_reg  <= TX_SEND;
        end

        // The device samples on its rising edge, so each new bit is put on
        // the line right after a fall. A 1 is sent by releasing the line.
        TX_SEND: begin
          if (cnt_reg == TIMEOUT_LAST) begin
            data_oe_reg <= 1'b0;
            state_reg   <= TX_FAIL;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (clk_fall) begin
              data_oe_reg <= ~shreg_reg[0];
              shreg_reg   <= {1'b1, shreg_reg[PS2_TX_SHIFT_BITS-1:1]};
              bitcnt_reg  <= bitcnt_reg + 4'd1;
              if (bitcnt_reg == LAST_BIT_IDX) begin
                state_reg <= TX_ACK;
              end
            end
          end
        end

        // Device pulls data low during its next clock to acknowledge.
        TX_ACK: begin
          data_oe_reg <= 1'b0;
          if (cnt_reg == TIMEOUT_LAST) begin
            state_reg <= TX_FAIL;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (clk_fall) begin
              state_reg <= data_sync ? TX_FAIL : TX_DONE;
            end
          end
        end

        // Report only once the device has let go of both lines, so the
        // receiver does not see the tail of the ACK as a new frame.
        TX_DONE: begin
          clk_oe_reg  <= 1'b0;
          data_oe_reg <= 1'b0;
          if (clk_sync && data_sync) begin
            state_reg <= TX_IDLE;
          end
        end

        // Lines are released for this cycle either way; a retry re-enters
        // the inhibit phase from the latched frame.
        TX_FAIL: begin
          data_oe_reg <= 1'b0;
          if (retry_left) begin
            cnt_reg    <= '0;
            clk_oe_reg <= 1'b1;
            state_reg  <= TX_INHIBIT;
          end else begin
            clk_oe_reg <= 1'b0;
            state_reg  <= TX_IDLE;
          end
        end

        default: begin
          clk_oe_reg  <= 1'b0;
          data_oe_reg <= 1'b0;
          state_reg   <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx_ready    = (state_reg == TX_IDLE);
  assign tx_busy     = ~tx_ready;
  // DONE leaves on exactly the cycle this is high, so it is a single pulse.
  assign tx_done     = (state_reg == TX_DONE) && clk_sync && data_sync;
  // FAIL lasts one cycle; with retries pending it is silent.
  assign tx_err      = (state_reg == TX_FAIL) && !retry_left;
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//   Self-checking bench for ps2_host_tx with a keyboard-side BFM.
//   The device clock runs at 40 board cycles per period, i.e. the 50 MHz /
//   12.5 kHz ratio scaled down by 100, with INHIBIT and TIMEOUT scaled alike.
//   Works with or without PS2_TX_RETRY_EN; the reference model follows the
//   same build option.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

  import ps2_pkg::*;

  localparam int INH   = 50;
  localparam int TO    = 7500;
  localparam int HALF  = 20;
  localparam int CNTW  = 16;
  localparam int MAXR  = 2;
  localparam int BOUND = 20000;
  localparam int NEVER = 99;   // device that never acknowledges

  logic       board_clk = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  logic bfm_clk_low  = 1'b0;
  logic bfm_data_low = 1'b0;

  // open-drain wired-AND with pull-ups
  assign ps2_clk_in  = ~(ps2_clk_oe === 1'b1) & ~bfm_clk_low;
  assign ps2_data_in = ~(ps2_data_oe === 1'b1) & ~bfm_data_low;

  always #5 board_clk = ~board_clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CNTW),
    .MAX_RETRY      (MAXR)
  ) dut (
    .board_clk   (board_clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Line monitor: pulse counts, inhibit length, timing marks
  // ---------------------------------------------------------------------------
  int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   inh_runs = 0, busy_falls = 0, inh_len = 0, last_inh = 0;
  int   req_exit_cyc = 0, err_cyc = 0;
  logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0, prev_busy = 1'b0;

  always @(negedge board_clk) begin
    cyc <= cyc + 1;
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe === 1'b1 && prev_clk_oe !== 1'b1) inh_runs <= inh_runs + 1;
    if (ps2_clk_oe === 1'b1 && ps2_data_oe !== 1'b1) begin
      inh_len <= inh_len + 1;
    end else begin
      if (ps2_clk_oe === 1'b1 && prev_data_oe !== 1'b1) last_inh <= inh_len;
      inh_len <= 0;
    end
    if (prev_clk_oe === 1'b1 && ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1)
      req_exit_cyc <= cyc;
    if (prev_busy === 1'b1 && tx_busy === 1'b0) busy_falls <= busy_falls + 1;
    prev_clk_oe  <= ps2_clk_oe;
    prev_data_oe <= ps2_data_oe;
    prev_busy    <= tx_busy;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Bit i is what the device reads on its (i+1)-th rising clock edge.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = d[i];
    f[8] = (($countones(d) % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // Number of frames sent when the device refuses the first `nacks` of them.
  function automatic int model_attempts(input int nacks);
`ifdef PS2_TX_RETRY_EN
    return (nacks <= MAXR) ? nacks + 1 : MAXR + 1;
`else
    return 1 + 0 * nacks;
`endif
  endfunction

  function automatic logic model_done(input int nacks);
    return (nacks < model_attempts(nacks));
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < BOUND) begin
      @(negedge board_clk);
      n++;
    end
    chk({tag, "_idle"}, {31'b0, tx_ready}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    @(negedge board_clk);
    while (tx_ready !== 1'b1 && n < BOUND) begin
      @(negedge board_clk);
      n++;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge board_clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard side of one host frame. Returns early after `abort_after` data
  // bits (when >= 0), or right after the request when silent.
  task automatic bfm_frame(input string tag, input bit ack, input bit silent,
                           input int abort_after, output logic [9:0] bits);
    int n = 0;
    bits = '0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && n < BOUND) begin
      @(negedge board_clk);
      n++;
    end
    chk({tag, "_request"}, {31'b0, (n < BOUND)}, 32'd1);
    if (silent || n >= BOUND) return;
    repeat (HALF) @(negedge board_clk);
    for (int i = 0; i < 10; i++) begin
      if (i == abort_after) return;
      bfm_clk_low = 1'b1;
      repeat (HALF) @(negedge board_clk);
      bfm_clk_low = 1'b0;
      @(negedge board_clk);
      bits[i] = ps2_data_in;
      repeat (HALF - 1) @(negedge board_clk);
    end
    bfm_data_low = ack;
    bfm_clk_low  = 1'b1;
    repeat (HALF) @(negedge board_clk);
    bfm_clk_low  = 1'b0;
    repeat (HALF) @(negedge board_clk);
    bfm_data_low = 1'b0;
  endtask

  // One command from request to idle, checked against the model.
  task automatic run_frame(input string tag, input logic [7:0] d, input int nacks,
                           input bit silent, input bit hold_off);
    int d0, e0, r0, b0, att;
    logic [9:0] bits;
    logic exp_done;
    d0 = done_cnt; e0 = err_cnt; r0 = inh_runs; b0 = busy_falls;
    att      = model_attempts(nacks);
    exp_done = model_done(nacks);
    send_byte(d);
    if (hold_off) begin
      // a second request while busy must be held off, not queued
      tx_data  = ~d;
      tx_valid = 1'b1;
      repeat (10) @(negedge board_clk);
      chk({tag, "_holdoff_ready"}, {31'b0, tx_ready}, 32'd0);
      tx_valid = 1'b0;
    end
    for (int a = 0; a < att; a++) begin
      bfm_frame(tag, (a >= nacks), silent, -1, bits);
      if (!silent) chk({tag, "_bits"}, {22'b0, bits}, {22'b0, model_frame(d)});
    end
    wait_idle(tag);
    repeat (3) @(negedge board_clk);
    $display("frame %s data=%02h attempts=%0d done=%0d err=%0d inhibit=%0d",
             tag, d, inh_runs - r0, done_cnt - d0, err_cnt - e0, last_inh);
    chk({tag, "_done_pulses"}, done_cnt - d0, {31'b0, exp_done});
    chk({tag, "_err_pulses"},  err_cnt - e0,  {31'b0, ~exp_done});
    chk({tag, "_attempts"},    inh_runs - r0, att);
    chk({tag, "_busy_falls"},  busy_falls - b0, 32'd1);
    chk({tag, "_inhibit_len"}, {31'b0, (last_inh >= INH)}, 32'd1);
    chk({tag, "_lines_free"},  {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    chk({tag, "_no_overlap"},  both_cnt, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [9:0] bits;
    logic [7:0] d;
    int         nacks;

    // reset state
    reset = 1'b1;
    repeat (3) @(negedge board_clk);
    chk("rst_ready",   {31'b0, tx_ready},    32'd1);
    chk("rst_busy",    {31'b0, tx_busy},     32'd0);
    chk("rst_done",    {31'b0, tx_done},     32'd0);
    chk("rst_err",     {31'b0, tx_err},      32'd0);
    chk("rst_clk_oe",  {31'b0, ps2_clk_oe},  32'd0);
    chk("rst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge board_clk);

    // clock falls while idle are ignored
    bfm_clk_low = 1'b1;
    repeat (5) @(negedge board_clk);
    bfm_clk_low = 1'b0;
    repeat (8) @(negedge board_clk);
    chk("idle_fall_busy",   {31'b0, tx_busy},    32'd0);
    chk("idle_fall_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);

    // set-LEDs, acknowledged, with a held-off second request
    run_frame("set_leds", PS2_CMD_SET_LEDS, 0, 1'b0, 1'b1);

    // parity corners
    run_frame("byte01", 8'h01, 0, 1'b0, 1'b0);
    run_frame("byte00", 8'h00, 0, 1'b0, 1'b0);

    // device never acknowledges
    run_frame("nack", PS2_CMD_ECHO, NEVER, 1'b0, 1'b0);
    chk("nack_ready", {31'b0, tx_ready}, 32'd1);

    // device never clocks: timeout measured from clock release
    run_frame("silent", PS2_CMD_RESET, NEVER, 1'b1, 1'b0);
    chk("timeout_cycles", err_cyc - req_exit_cyc, TO);

    // reset after the fourth data bit (bit 3 of 0xA5 is 0, so data is driven)
    send_byte(8'hA5);
    bfm_frame("abort", 1'b1, 1'b0, 4, bits);
    chk("abort_bits", {28'b0, bits[3:0]}, {28'b0, 4'b0101});
    chk("abort_pre_data_oe", {31'b0, ps2_data_oe}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_lines_free", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    @(negedge board_clk);
    chk("abort_ready", {31'b0, tx_ready}, 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge board_clk);
    run_frame("after_reset", PS2_CMD_RESET, 0, 1'b0, 1'b0);

    // two refusals then an acknowledge (recovers only in the retry build)
    run_frame("nack2_ack", PS2_CMD_ECHO, 2, 1'b0, 1'b0);

    // random bytes and device behaviour
    for (int k = 0; k < 6; k++) begin
      d     = 8'($urandom);
      nacks = $urandom_range(0, 3);
      run_frame($sformatf("rand%0d_n%0d", k, nacks), d, nacks, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
